// File: rtl/sift_mem_pkg.sv
// sift_mem_pkg: constants and types shared by the blur-image memory arbiter.
// Geometry of the 480x5120 blur SRAM and the arbiter FSM states.
package sift_mem_pkg;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 5120;
   localparam int DEPTH     = 480;
   localparam int N_REQ_DEF = 3;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

endpackage

// File: rtl/blur_mem_arbiter_if.sv
// blur_mem_arbiter_if: requester-side bus of the blur SRAM arbiter.
// Engines use the master modport, the arbiter uses the slave modport.
interface blur_mem_arbiter_if
   import sift_mem_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        lock;
   logic [N_REQ-1:0]        we;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]       rdata;
   logic                    err;
   logic [IW-1:0]           err_id;

   modport master (
      output req, lock, we, addr, wdata,
      input  gnt, rvalid, rdata, err, err_id
   );

   modport slave (
      input  req, lock, we, addr, wdata,
      output gnt, rvalid, rdata, err, err_id
   );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotate-and-priority-encode picker.
// Returns the first requester at or above ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   // Scan from ptr upward and keep the first active requester.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/blur_mem_arbiter.sv
// blur_mem_arbiter: round-robin owner of the single-port blur SRAM.
// Locked bursts, tagged 1-cycle read return and out-of-range guard.
module blur_mem_arbiter
   import sift_mem_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   blur_mem_arbiter_if.slave  bus,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_din,
   input  logic [DATA_W-1:0]  mem_dout
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic              run_q, run_d;
   logic              rv_q, rv_d;
   logic [IW-1:0]     rtag_q, rtag_d;
   logic              err_q, err_d;
   logic [IW-1:0]     err_id_q, err_id_d;
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;

   logic              active;
   logic              hold;
   logic              granted;
   logic              addr_ok;
   logic [IW-1:0]     ptr_eff;
   logic [IW-1:0]     win;
   logic [IW-1:0]     pick_idx;
   logic [N_REQ-1:0]  pick_gnt;
   logic              pick_any;
   logic [ADDR_W-1:0] win_addr;

   function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
      return (i == LAST) ? '0 : i + IW'(1);
   endfunction

   // Outputs stay quiet until the first edge after reset release.
   assign active  = rst_n & run_q;
   assign hold    = (state_q == ARB_LOCKED)
                  & bus.req[owner_q] & bus.lock[owner_q];
   assign ptr_eff = (state_q == ARB_LOCKED) ? inc_wrap(owner_q)
                                            : rr_ptr_q;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req (bus.req),
      .ptr (ptr_eff),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Select the winner and steer its access onto the SRAM port.
   always_comb begin
      win      = hold ? owner_q : pick_idx;
      granted  = active & (hold | pick_any);
      bus.gnt  = '0;
      if (granted) begin
         bus.gnt = hold ? (N_REQ'(1) << owner_q) : pick_gnt;
      end
      win_addr = bus.addr[int'(win)*ADDR_W +: ADDR_W];
      addr_ok  = addr_in_range(win_addr);
      mem_we   = granted & bus.we[win] & addr_ok;
      mem_din  = '0;
      if (granted) begin
         mem_din = bus.wdata[int'(win)*DATA_W +: DATA_W];
      end
      if (!rst_n) begin
         mem_addr = '0;
      end else if (granted) begin
         mem_addr = win_addr;
      end else begin
         mem_addr = addr_hold_q;
      end
   end

   // Lock ownership, round-robin pointer, read tag and error capture.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      run_d       = 1'b1;
      rv_d        = granted & ~bus.we[win] & addr_ok;
      rtag_d      = win;
      err_d       = granted & ~addr_ok;
      err_id_d    = err_d ? win : err_id_q;
      addr_hold_d = mem_addr;
      if (state_q == ARB_LOCKED && !hold) begin
         state_d  = ARB_IDLE;
         rr_ptr_d = ptr_eff;
      end
      if (granted && !hold) begin
         if (bus.lock[win]) begin
            state_d = ARB_LOCKED;
            owner_d = win;
         end else begin
            rr_ptr_d = inc_wrap(win);
         end
      end
   end

   // Read data returns one cycle later, tagged to its requester.
   always_comb begin
      bus.rvalid = '0;
      if (rv_q) begin
         bus.rvalid[rtag_q] = 1'b1;
      end
      bus.rdata  = mem_dout;
      bus.err    = err_q;
      bus.err_id = err_id_q;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         run_q       <= 1'b0;
         rv_q        <= 1'b0;
         rtag_q      <= '0;
         err_q       <= 1'b0;
         err_id_q    <= '0;
         addr_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         run_q       <= run_d;
         rv_q        <= rv_d;
         rtag_q      <= rtag_d;
         err_q       <= err_d;
         err_id_q    <= err_id_d;
         addr_hold_q <= addr_hold_d;
      end
   end

endmodule
